halloween_sequencer: RTL
========================

# halloween_sequencer

Parametrised opcode sequencer for the Halloween decoration controller. It holds a loadable program of SLOTS 4-bit opcodes and steps through them on a dwell timer. Each opcode is decoded into registered actuator outputs: a one-hot opcode bus, a colour register, a sound trigger pulse and effect levels. It replaces the fixed 4-channel counter/mux/decoder path, adding a program store, per-step dwell, a RESET jump and illegal-opcode detection.

## Interface
- SLOTS, 4: program depth, at least 2; ADDR_W = clog2(SLOTS) (localparam).
- DWELL, 4: clock cycles each non-RESET step is held, at least 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- on  in  1  run enable, level-sensitive.
- load  in  1  program write strobe.
- load_addr  in  ADDR_W  slot to write.
- load_data  in  4  opcode to write.
- step  out  ADDR_W  current slot index.
- opcode  out  4  opcode of current step.
- onehot  out  16  one-hot decode of opcode (bit = opcode value).
- color  out  2  00 green, 01 purple, 10 orange.
- color_valid  out  1  color has been set since reset or RESET opcode.
- sound_pulse  out  1  one-cycle trigger.
- sound_id  out  2  00 scream, 01 cackle, 10 boo.
- effect  out  3  bit0 wave hands, bit1 move jaw, bit2 fog.
- running  out  1  FSM in RUN.
- bad_op  out  1  sticky illegal-opcode flag.

## Operation
- Opcode classes:
  - 0000 NOP/ON.
  - 0001 RESET.
  - 01xx colour: xx=11 is illegal.
  - 10xx sound: xx=11 is illegal.
  - 11xx effect: xx=11 is illegal.
- FSM states are IDLE, RUN and DONE (DONE is not reachable when HALLOWEEN_LOOP_EN is defined).
- IDLE:
  - running=0, opcode=0, onehot=0, effect=0.
  - First rising edge with on=1 is the entry edge of slot 0 → RUN.
- Step entry edge: step, opcode and onehot load from the new slot. At the same edge:
  - Colour op: color=xx, color_valid=1.
  - Sound op: sound_pulse=1 and sound_id=xx for one cycle.
  - Effect op: effect = one-hot of xx, held for the whole step; effect=0 for every other opcode.
  - RESET: effect=0 and color_valid=0 (color value retained). The step lasts exactly 1 cycle, then slot 0 is entered, regardless of the macro.
  - Illegal op (0011, 0111, 1011, 1111): bad_op=1 and the step acts as NOP. bad_op is cleared only by rst.
- Non-RESET steps last DWELL cycles; the next entry edge is DWELL edges later.
- After the last slot (SLOTS-1), behaviour is set by the macro (see Configuration).
- If on=0 at any edge in RUN or DONE → IDLE at that edge: opcode, onehot, effect, sound_pulse and running are cleared; color and color_valid are retained.
- Program store:
  - Written on an edge with load=1, only in IDLE or DONE. Writes in RUN are ignored.
  - load_addr ≥ SLOTS is ignored.
  - If load and on rise together in IDLE with load_addr=0, slot 0 executes the new data (write-through).
- A slot that is RESET, including slot 0 itself, restarts at slot 0. A program of RESET in slot 0 cycles 1-cycle steps indefinitely; this is legal behaviour.

## Timing
- Reset (async, immediate):
  - All outputs 0.
  - Program store cleared to NOP.
  - FSM → IDLE, dwell counter 0.
- Latency: outputs change on the entry edge itself; there is no extra pipeline stage between step and the decoded outputs.
- sound_pulse is high exactly one cycle per sound step, including DWELL=1.
- With DWELL=1 a new step is entered every edge.
- Dwell counter is ceil(log2(DWELL+1)) bits and resets to 0 at each entry edge.
- rst asserted mid-step aborts immediately. On rst release the block stays in IDLE until the first edge with on=1.

## Configuration
- HALLOWEEN_LOOP_EN defined: after slot SLOTS-1 dwell expires, slot 0 is entered. DONE is unused and the sequence loops while on=1.
- HALLOWEEN_LOOP_EN undefined: after slot SLOTS-1 dwell expires → DONE. In DONE:
  - running=0, opcode=0, onehot=0, effect=0; color is retained.
  - The block stays in DONE until on=0 (→ IDLE); on must drop and rise again to restart.

## Test plan
- Reset: assert rst mid-run → all outputs 0 at once; after release and on=1, every slot reads 0000 and bad_op stays 0.
- SLOTS=4, DWELL=4, program 0100,1000,1100,0110, on=1 → expected response:
  - Slot 0: color=00, color_valid=1.
  - Slot 1 (edge +4): sound_pulse=1 for 1 cycle, sound_id=00.
  - Slot 2 (edge +8): effect=001 for 4 cycles.
  - Slot 3 (edge +12): color=10, effect=000.
- Wrap, same program: edge +16 → with HALLOWEEN_LOOP_EN, step=0 and color=00; without it, running=0 and opcode=0 until on toggles.
- Slot 2 = 0001: slot entry order 0 (4 cycles), 1 (4 cycles), 2 (1 cycle), 0; color_valid drops at the slot 2 edge.
- Slot 1 = 1011 → bad_op=1 at that entry edge and stays 1 through the wrap; effect=000 during slot 1.
- load=1, addr 0, data 1110 while running → ignored (the next pass of slot 0 is unchanged). The same load in IDLE with on rising → fog (effect=100) at the first edge.

Source files
------------

// File: rtl/halloween_sequencer.sv
// halloween_sequencer
//   Opcode sequencer for the Halloween decoration controller. A loadable
//   program of SLOTS 4-bit opcodes is stepped through on a DWELL-cycle timer.
//   Each opcode is decoded into registered actuator outputs on the edge that
//   enters its step.
//
//   Opcodes: 0000 NOP, 0001 RESET (1-cycle step, then slot 0),
//            01xx colour, 10xx sound, 11xx effect; any xx=11 is illegal.
//
//   Build option: define HALLOWEEN_LOOP_EN to loop back to slot 0 after the
//   last slot. Without it the block parks in DONE until on drops.
//
// Parameters
//   SLOTS   program depth (>= 2)
//   DWELL   cycles each non-RESET step is held (>= 1)
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   on           run enable (level)
//   load         program write strobe (honoured in IDLE/DONE only)
//   load_addr    slot to write
//   load_data    opcode to write
//   step         current slot index
//   opcode       opcode of current step
//   onehot       one-hot decode of opcode
//   color        00 green, 01 purple, 10 orange
//   color_valid  colour set since reset or last RESET opcode
//   sound_pulse  one-cycle sound trigger
//   sound_id     00 scream, 01 cackle, 10 boo
//   effect       bit0 wave hands, bit1 move jaw, bit2 fog
//   running      FSM in RUN
//   bad_op       sticky illegal-opcode flag
module halloween_sequencer #(
   parameter int SLOTS = 4,
   parameter int DWELL = 4,
   localparam int ADDR_W = $clog2(SLOTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              on,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [3:0]        load_data,
   output logic [ADDR_W-1:0] step,
   output logic [3:0]        opcode,
   output logic [15:0]       onehot,
   output logic [1:0]        color,
   output logic              color_valid,
   output logic              sound_pulse,
   output logic [1:0]        sound_id,
   output logic [2:0]        effect,
   output logic              running,
   output logic              bad_op
);

   localparam int         CNT_W    = $clog2(DWELL + 1);
   localparam logic [3:0] OP_RESET = 4'b0001;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [3:0]        prog [SLOTS];

   logic [ADDR_W-1:0] step_nx;
   logic [3:0]        opcode_nx;
   logic [15:0]       onehot_nx;
   logic [1:0]        color_nx, sound_id_nx;
   logic              color_valid_nx, sound_pulse_nx, bad_op_nx;
   logic [2:0]        effect_nx;

   logic              prog_we;
   logic              entry;
   logic [ADDR_W-1:0] entry_slot;
   logic [3:0]        entry_op;

   // Program writes are blocked while a sequence is running.
   assign prog_we = load && (state != RUN) && (int'(load_addr) < SLOTS);
   assign running = (state == RUN);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_nx       = state;
      cnt_nx         = cnt;
      step_nx        = step;
      opcode_nx      = opcode;
      onehot_nx      = onehot;
      color_nx       = color;
      color_valid_nx = color_valid;
      sound_pulse_nx = 1'b0;
      sound_id_nx    = sound_id;
      effect_nx      = effect;
      bad_op_nx      = bad_op;
      entry          = 1'b0;
      entry_slot     = '0;
      entry_op       = 4'b0000;

      case (state)
         IDLE: if (on) entry = 1'b1;
         RUN: begin
            if (!on) begin
               state_nx = IDLE;
            end else if (opcode == OP_RESET || cnt == CNT_W'(DWELL - 1)) begin
               if (opcode != OP_RESET && step == ADDR_W'(SLOTS - 1)) begin
`ifdef HALLOWEEN_LOOP_EN
                  entry = 1'b1;
`else
                  state_nx = DONE;
`endif
               end else begin
                  entry      = 1'b1;
                  entry_slot = (opcode == OP_RESET) ? '0 : step + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: if (!on) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      if (entry) begin
         // A write landing on the slot being entered is passed straight through.
         entry_op  = (prog_we && load_addr == entry_slot) ? load_data : prog[entry_slot];
         state_nx  = RUN;
         cnt_nx    = '0;
         step_nx   = entry_slot;
         opcode_nx = entry_op;
         onehot_nx = 16'h0001 << entry_op;
         effect_nx = 3'b000;
         if (entry_op[1:0] == 2'b11) begin
            bad_op_nx = 1'b1;              // illegal: flag and behave as NOP
         end else begin
            case (entry_op[3:2])
               2'b00: if (entry_op == OP_RESET) color_valid_nx = 1'b0;
               2'b01: begin
                  color_nx       = entry_op[1:0];
                  color_valid_nx = 1'b1;
               end
               2'b10: begin
                  sound_pulse_nx = 1'b1;
                  sound_id_nx    = entry_op[1:0];
               end
               default: effect_nx = 3'b001 << entry_op[1:0];
            endcase
         end
      end else if (state_nx != RUN) begin
         // Leaving RUN (to IDLE or DONE): actuators off, colour state kept.
         opcode_nx = 4'b0000;
         onehot_nx = 16'h0000;
         effect_nx = 3'b000;
         cnt_nx    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         step        <= '0;
         opcode      <= 4'b0000;
         onehot      <= 16'h0000;
         color       <= 2'b00;
         color_valid <= 1'b0;
         sound_pulse <= 1'b0;
         sound_id    <= 2'b00;
         effect      <= 3'b000;
         bad_op      <= 1'b0;
         // NOTE: the program store is reset so a fresh start always runs NOPs.
         for (int i = 0; i < SLOTS; i++) prog[i] <= 4'b0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignment only.
         state       <= state_nx;
         cnt         <= cnt_nx;
         step        <= step_nx;
         opcode      <= opcode_nx;
         onehot      <= onehot_nx;
         color       <= color_nx;
         color_valid <= color_valid_nx;
         sound_pulse <= sound_pulse_nx;
         sound_id    <= sound_id_nx;
         effect      <= effect_nx;
         bad_op      <= bad_op_nx;
         if (prog_we) prog[load_addr] <= load_data;
      end
   end

endmodule
